// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider with per-channel period/high time,
// double-buffered config writes applied at period boundaries, and rise ticks.
module clkdiv_multi #(
  parameter int CHANNELS      = 4,
  parameter int WIDTH         = 16,
  parameter int DEFAULT_RATIO = 2,
  parameter int DEFAULT_HIGH  = 1,
  parameter int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [WIDTH-1:0]    cfg_ratio,
  input  logic [WIDTH-1:0]    cfg_high,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  localparam int NSEL = 1 << CW;

  logic [NSEL-1:0] pending_pad;
  logic            chan_ok;
  logic            cfg_accept;
  logic            cfg_good;

  // Padding bits read as "not pending", so an out-of-range channel looks ready.
  always_comb begin
    pending_pad                 = '0;
    pending_pad[CHANNELS-1:0]   = pending;
  end

  assign chan_ok    = 32'(cfg_chan) < 32'(CHANNELS);
  assign cfg_ready  = ~pending_pad[cfg_chan];
  assign cfg_accept = cfg_valid & cfg_ready;
  assign cfg_good   = cfg_accept & chan_ok & (cfg_ratio >= WIDTH'(2));

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) cfg_err <= 1'b0;
    else        cfg_err <= cfg_accept & ~cfg_good;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] ratio_q;
    logic [WIDTH-1:0] high_q;
    logic [WIDTH-1:0] sh_ratio_q;
    logic [WIDTH-1:0] sh_high_q;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] ratio_eff;
    logic [WIDTH-1:0] high_eff;
    logic             pend_q;
    logic             clk_q;
    logic             tick_q;
    logic             wrap;
    logic             apply;
    logic             wr_hit;
    logic             rise;

    assign wr_hit = cfg_good && (32'(cfg_chan) == 32'(i));
    assign wrap   = cnt_q >= (ratio_q - WIDTH'(1));
    // A pending shadow lands at the wrap, or straight away if the channel is stopped.
    assign apply  = pend_q & (~enable[i] | wrap);

    always_comb begin
      ratio_eff = apply ? sh_ratio_q : ratio_q;
      high_eff  = apply ? sh_high_q  : high_q;
      cnt_next  = (!enable[i] || wrap) ? '0 : cnt_q + WIDTH'(1);
      // Extra bit keeps H >= R from wrapping the threshold sum.
      rise      = enable[i] &
                  (({1'b0, cnt_next} + {1'b0, high_eff}) >= {1'b0, ratio_eff});
    end

    always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
        cnt_q      <= '0;
        ratio_q    <= WIDTH'(DEFAULT_RATIO);
        high_q     <= WIDTH'(DEFAULT_HIGH);
        sh_ratio_q <= '0;
        sh_high_q  <= '0;
        pend_q     <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        cnt_q  <= cnt_next;
        clk_q  <= rise;
        tick_q <= rise & ~clk_q;
        if (apply) begin
          ratio_q <= sh_ratio_q;
          high_q  <= sh_high_q;
          pend_q  <= 1'b0;
        end
        if (wr_hit) begin
          if (enable[i]) begin
            sh_ratio_q <= cfg_ratio;
            sh_high_q  <= cfg_high;
            pend_q     <= 1'b1;
          end else begin
            ratio_q <= cfg_ratio;
            high_q  <= cfg_high;
          end
        end
      end
    end

    assign pending[i] = pend_q;
    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi: integer period model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_clkdiv_multi;
  localparam int NCH = 5;
  localparam int W   = 16;
  localparam int CW  = 3;

  logic           clk_in = 1'b0;
  logic           reset  = 1'b1;
  logic [NCH-1:0] enable;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_chan;
  logic [W-1:0]   cfg_ratio;
  logic [W-1:0]   cfg_high;
  logic           cfg_err;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  int n_tests = 0;
  int n_fail  = 0;

  clkdiv_multi #(.CHANNELS(NCH), .WIDTH(W), .DEFAULT_RATIO(2), .DEFAULT_HIGH(1)) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_chan(cfg_chan), .cfg_ratio(cfg_ratio),
    .cfg_high(cfg_high), .cfg_err(cfg_err), .pending(pending),
    .clk_out(clk_out), .tick(tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  // Model: each channel tracks its position within the current period.
  int m_r[NCH], m_h[NCH], s_r[NCH], s_h[NCH], pos[NCH];
  bit m_pend[NCH], m_clk[NCH], m_tick[NCH];
  bit m_err;

  always @(posedge clk_in or negedge reset) begin
    int ch;
    bit acc, ok, wr, nv;
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_r[i] = 2; m_h[i] = 1; s_r[i] = 0; s_h[i] = 0; pos[i] = 0;
        m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
      end
      m_err = 0;
    end else begin
      ch    = int'(cfg_chan);
      acc   = cfg_valid && (ch >= NCH || !m_pend[ch]);
      ok    = acc && (int'(cfg_ratio) >= 2) && (ch < NCH);
      m_err = acc && !ok;
      for (int i = 0; i < NCH; i++) begin
        wr = ok && (ch == i);
        if (!enable[i]) begin
          if (m_pend[i]) begin m_r[i] = s_r[i]; m_h[i] = s_h[i]; m_pend[i] = 0; end
          if (wr) begin m_r[i] = int'(cfg_ratio); m_h[i] = int'(cfg_high); end
          pos[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
        end else begin
          pos[i] = pos[i] + 1;
          if (pos[i] >= m_r[i]) begin
            pos[i] = 0;
            if (m_pend[i]) begin m_r[i] = s_r[i]; m_h[i] = s_h[i]; m_pend[i] = 0; end
          end
          nv        = (pos[i] + m_h[i]) >= m_r[i];
          m_tick[i] = nv && !m_clk[i];
          m_clk[i]  = nv;
          if (wr) begin s_r[i] = int'(cfg_ratio); s_h[i] = int'(cfg_high); m_pend[i] = 1; end
        end
      end
    end
  end

  always @(negedge clk_in) begin
    logic [NCH-1:0] e_clk, e_tick, e_pend;
    logic e_ready;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        e_clk[i] = m_clk[i]; e_tick[i] = m_tick[i]; e_pend[i] = m_pend[i];
      end
      e_ready = (int'(cfg_chan) >= NCH) ? 1'b1 : !m_pend[cfg_chan];
      check("model_clk_out", 32'(clk_out), 32'(e_clk));
      check("model_tick", 32'(tick), 32'(e_tick));
      check("model_pending", 32'(pending), 32'(e_pend));
      check("model_cfg_err", 32'(cfg_err), 32'(m_err));
      check("model_cfg_ready", 32'(cfg_ready), 32'(e_ready));
    end
  end

  initial begin
    logic [4:0] seq;
    int ones, ticks;
    bit found;
    enable = '1; cfg_valid = 0; cfg_chan = '0; cfg_ratio = '0; cfg_high = '0;
    #1 reset = 0;
    #2;
    check("reset_clk_out", 32'(clk_out), 32'h0);
    check("reset_pending", 32'(pending), 32'h0);
    #19 reset = 1;

    // Defaults (2,1): all channels toggle every cycle.
    step();
    check("dflt_clk_e1", 32'(clk_out), 32'h1F);
    check("dflt_tick_e1", 32'(tick), 32'h1F);
    step();
    check("dflt_clk_e2", 32'(clk_out), 32'h00);
    check("dflt_tick_e2", 32'(tick), 32'h00);
    step();

    // Ch1 R=5 H=2, accepted on a wrap edge: applied at the following wrap.
    cfg_valid = 1; cfg_chan = 3'd1; cfg_ratio = 16'd5; cfg_high = 16'd2;
    step();
    cfg_valid = 0;
    check("ch1_pending_set", 32'(pending), 32'h02);
    check("ch1_ready_busy", 32'(cfg_ready), 32'h0);
    step();
    check("ch1_pending_hold", 32'(pending), 32'h02);
    step();
    check("ch1_pending_clr", 32'(pending), 32'h00);
    seq = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      seq = {seq[3:0], clk_out[1]};
    end
    check("ch1_wave", 32'(seq), 32'h06);

    // Rejected writes.
    cfg_valid = 1; cfg_chan = 3'd2; cfg_ratio = 16'd1; cfg_high = 16'd0;
    step();
    cfg_valid = 0;
    check("err_ratio1", 32'(cfg_err), 32'h1);
    cfg_valid = 1; cfg_chan = 3'd5; cfg_ratio = 16'd4; cfg_high = 16'd1;
    check("ready_oob", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 0;
    check("err_oob", 32'(cfg_err), 32'h1);
    step();
    check("err_clear", 32'(cfg_err), 32'h0);
    check("err_no_pending", 32'(pending), 32'h00);

    // Ch3 H=0 then H=R.
    cfg_valid = 1; cfg_chan = 3'd3; cfg_ratio = 16'd6; cfg_high = 16'd0;
    step();
    cfg_valid = 0;
    step(); step();
    ones = 0; ticks = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      ones += int'(clk_out[3]); ticks += int'(tick[3]);
    end
    check("ch3_h0_ones", 32'(ones), 32'd0);
    check("ch3_h0_ticks", 32'(ticks), 32'd0);
    cfg_valid = 1; cfg_chan = 3'd3; cfg_ratio = 16'd6; cfg_high = 16'd6;
    step();
    cfg_valid = 0;
    ticks = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      ticks += int'(tick[3]);
    end
    check("ch3_hr_ticks", 32'(ticks), 32'd1);
    check("ch3_hr_high", 32'(clk_out[3]), 32'h1);

    // Ch0: disable while high, direct write while stopped, re-enable.
    found = 0;
    for (int k = 0; k < 4 && !found; k++) begin
      if (clk_out[0]) found = 1;
      else step();
    end
    check("ch0_found_high", 32'(found), 32'h1);
    enable[0] = 0;
    step();
    check("ch0_dis_low", 32'(clk_out[0]), 32'h0);
    cfg_valid = 1; cfg_chan = 3'd0; cfg_ratio = 16'd4; cfg_high = 16'd1;
    step();
    cfg_valid = 0;
    check("ch0_direct_nopend", 32'(pending[0]), 32'h0);
    step();
    enable[0] = 1;
    step(); step();
    check("ch0_reen_low", 32'(clk_out[0]), 32'h0);
    step();
    check("ch0_reen_rise", 32'(clk_out[0]), 32'h1);

    // Reset mid-period with ch1 pending.
    cfg_valid = 1; cfg_chan = 3'd1; cfg_ratio = 16'd7; cfg_high = 16'd3;
    step();
    cfg_valid = 0;
    check("ch1_pend_prerst", 32'(pending[1]), 32'h1);
    #1 reset = 0;
    #1;
    check("rst_clk_out", 32'(clk_out), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_cfg_err", 32'(cfg_err), 32'h0);
    #20 reset = 1;
    step();
    check("post_rst_clk_e1", 32'(clk_out), 32'h1F);
    step();
    check("post_rst_clk_e2", 32'(clk_out), 32'h00);
    check("post_rst_pending", 32'(pending), 32'h00);
    for (int k = 0; k < 10; k++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/clkdiv_multi.md
# clkdiv_multi

Parametrised multi-channel successor to the single-ratio clock divider. It generates CHANNELS independent divided clocks from one `clk_in`, each with its own programmable period and high time, plus a one-cycle `tick` enable per channel. Ratio changes are double-buffered and applied only at period boundaries, so outputs never glitch. It sits between the board clock and the slow-rate logic: MAC sequencing, display scan and debounce.

## Interface
- CHANNELS, 4: number of independent divider channels (1..16).
- WIDTH, 16: width of the ratio, high-time and counter fields.
- DEFAULT_RATIO, 2: active period loaded at reset (≥2).
- DEFAULT_HIGH, 1: active high time loaded at reset.
- CW, max(1, clog2(CHANNELS)): width of the channel select (derived).

Ports:
- clk_in  in  1  single system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  CHANNELS  per-channel run enable.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  combinational; high when the addressed shadow is free.
- cfg_chan  in  CW  target channel.
- cfg_ratio  in  WIDTH  new period R in clk_in cycles.
- cfg_high  in  WIDTH  new high time H in cycles.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- pending  out  CHANNELS  shadow holds an unapplied config.
- clk_out  out  CHANNELS  registered divided clocks.
- tick  out  CHANNELS  one-cycle pulse on each clk_out rising edge.

## Operation
- Each channel has an active register pair (R, H), a shadow pair, a pending bit and a WIDTH-bit counter c.
- Enabled channel:
  - c advances 0..R-1 and wraps to 0.
  - clk_out is registered as (c_next ≥ R−H).
  - tick is registered as (clk_out_next & ~clk_out).
- Edge cases for H:
  - H=0: clk_out stays at 0 and tick never fires.
  - H≥R: clk_out stays at 1 and tick fires once, on the first rise only.
- Disabled channel (enable[i]=0): on the next edge c←0, clk_out←0, tick←0, and the channel holds there. Re-enable restarts from c=0.
- cfg handshake: a write is accepted when cfg_valid & cfg_ready. cfg_ready = ~pending[cfg_chan]; an out-of-range cfg_chan gives cfg_ready=1.
- Rejected writes (no state change, cfg_err=1 next cycle):
  - cfg_ratio < 2
  - cfg_chan ≥ CHANNELS
- Accepted write, enabled channel: shadow is written and pending set on the acceptance edge. On the wrap edge (c=R−1→0), active←shadow and pending clears. clk_out/tick for that edge use the new values.
- Accepted write, disabled channel: active is written directly on the acceptance edge and pending stays 0.
- Write accepted on the same edge the channel wraps: the new config goes to the shadow and is applied at the following wrap, not the current one.
- Channels are fully independent; only one config write per cycle.

## Timing
- Reset values: clk_out=0, tick=0, cfg_err=0, pending=0, every counter 0, active=(DEFAULT_RATIO, DEFAULT_HIGH), shadows cleared.
- Reset assertion clears all state immediately, without waiting for a clock edge. Reset mid-period or with a write pending discards the shadow.
- Example R=4, H=2, enable held high from reset release:
  - c after edges 1..4 = 1,2,3,0.
  - clk_out rises after edge 2 and falls after edge 4, then repeats.
  - period 4, 50% duty; tick high for the cycle after edges 2, 6, 10…
- First rise after enable: R−H edges.
- Config apply latency: from acceptance to the next wrap, at most R_old cycles.
- cfg_err latency: 1 cycle after the rejected request.

## Test plan
- Reset release, all enables high, defaults (2,1) -> every clk_out toggles each cycle (period 2); tick on alternate cycles; pending=0.
- Write ch1 R=5 H=2 mid-period -> pending[1]=1 and cfg_ready low for ch1 until the wrap. New waveform: 3 low / 2 high. Ch0 and ch2 unchanged; no runt pulse on ch1.
- Write ch2 R=1, then cfg_chan=CHANNELS -> cfg_err pulses once per write; ch2 keeps its old period; pending unchanged.
- Ch3 R=6 H=0, then H=6 -> first config: clk_out[3] constant 0, no tick. Second config: constant 1, a single tick.
- Drop enable[0] while clk_out[0]=1 and re-enable after 3 cycles -> clk_out[0] falls on the next edge, then rises R−H edges after re-enable.
- Assert reset mid-period with ch1 pending -> all outputs 0 immediately. After release, ch1 runs at DEFAULT_RATIO with pending cleared.
